// File: rtl/shared_resource_arbiter_if.sv
// Purpose: bundles the requester, resource and response signals of the shared resource arbiter.
// Latency: none, this is wiring only.
// Backpressure: a requester stalls while its grant bit is low; there is no ready path back to the resource.
interface shared_resource_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);
  localparam int OW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [DATA_W-1:0]         resource_output;
  logic [NUM_REQ-1:0]        grant;
  logic [OW-1:0]             owner;
  logic [DATA_W-1:0]         resource_input;
  logic                      resource_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic                      busy;

  // Environment side: the requesters and the resource.
  modport master (
    output req, req_data, resource_output,
    input  grant, owner, resource_input, resource_valid, rsp_data, rsp_valid, busy
  );

  // Arbiter side.
  modport slave (
    input  req, req_data, resource_output,
    output grant, owner, resource_input, resource_valid, rsp_data, rsp_valid, busy
  );
endinterface

// File: rtl/shared_resource_arbiter.sv
// Purpose: round-robin arbiter sharing one fixed-latency resource among NUM_REQ requesters, with responses tagged back to the issuer.
// Latency: grant is registered 1 cycle after req; a response appears on rsp_valid RES_LAT cycles after issue.
// Backpressure: requesters without a grant stall; the arbiter itself never stalls and accepts one issue per cycle.
module shared_resource_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 8,
  parameter int RES_LAT  = 1
) (
  input logic                      clk,
  input logic                      reset,
  shared_resource_arbiter_if.slave bus
);
  localparam int OW = $clog2(NUM_REQ);
  localparam int HW = $clog2(MAX_HOLD) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {S_IDLE = 1'b0, S_GRANTED = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [OW-1:0]      ptr_q, ptr_d;
  logic [HW-1:0]      hold_q, hold_d;

  logic [NUM_REQ-1:0] cand;
  logic               win_vld;
  logic [OW-1:0]      win_idx;
  logic [OW-1:0]      win_nxt;
  logic               owner_req;
  logic               take;

  logic [RES_LAT-1:0] tag_vld_q;
  logic [OW-1:0]      tag_own_q [RES_LAT];

  logic [DATA_W-1:0]  res_in;
  logic               res_vld;
  logic [NUM_REQ-1:0] rsp_vld;
  logic               busy;

  // The grant is one-hot, so masking req with it gives req[owner] without a variable index.
  assign owner_req = |(grant_q & bus.req);
  // While granted, the current owner is excluded so a forced handoff goes to someone else.
  assign cand      = (state_q == S_GRANTED) ? (bus.req & ~grant_q) : bus.req;

  // Round-robin search over the candidates, starting at ptr and wrapping.
  always_comb begin
    int idx;
    win_vld = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_vld && cand[idx]) begin
        win_vld = 1'b1;
        win_idx = OW'(idx);
      end
    end
    win_nxt = (win_idx == OW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
  end

  // State register: grant, owner, RR pointer and hold counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state: release, forced handoff after MAX_HOLD cycles, or keep the grant.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    take    = 1'b0;
    case (state_q)
      S_IDLE: take = win_vld;
      S_GRANTED: begin
        if (!owner_req) begin
          if (win_vld) begin
            take = 1'b1;
          end else begin
            state_d = S_IDLE;
            grant_d = '0;
            owner_d = '0;
            hold_d  = '0;
          end
        end else if (hold_q == HOLD_LAST) begin
          if (win_vld) take = 1'b1;
          else         hold_d = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: ;
    endcase
    if (take) begin
      state_d = S_GRANTED;
      grant_d = NUM_REQ'(1) << win_idx;
      owner_d = win_idx;
      ptr_d   = win_nxt;
      hold_d  = '0;
    end
  end

  // Outputs: resource mux from the registered grant, response tag decode, busy.
  always_comb begin
    res_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) res_in = bus.req_data[i*DATA_W +: DATA_W];
    end
    res_vld = owner_req;
    rsp_vld = tag_vld_q[RES_LAT-1] ? (NUM_REQ'(1) << tag_own_q[RES_LAT-1]) : '0;
    busy    = (|grant_q) | (|tag_vld_q);
  end

  // Issue tag shift pipeline: remembers who issued each in-flight resource operation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tag_vld_q <= '0;
      for (int i = 0; i < RES_LAT; i++) tag_own_q[i] <= '0;
    end else begin
      tag_vld_q[0] <= res_vld;
      tag_own_q[0] <= owner_q;
      for (int i = 1; i < RES_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_own_q[i] <= tag_own_q[i-1];
      end
    end
  end

  assign bus.grant          = grant_q;
  assign bus.owner          = owner_q;
  assign bus.resource_input = res_in;
  assign bus.resource_valid = res_vld;
  assign bus.rsp_data       = bus.resource_output;
  assign bus.rsp_valid      = rsp_vld;
  assign bus.busy           = busy;
endmodule

// File: tb/tb_shared_resource_arbiter.sv
// Purpose: self-checking bench for shared_resource_arbiter against a cycle-level reference model.
// Latency: checks every cycle at the falling edge, model advances once per rising edge.
// Backpressure: none, the bench drives req levels freely.
module tb_shared_resource_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int MH   = 2;
  localparam int RL   = 3;

  logic clk;
  logic reset;

  shared_resource_arbiter_if #(.NUM_REQ(NREQ), .DATA_W(DW)) bif ();

  shared_resource_arbiter #(
    .NUM_REQ(NREQ), .DATA_W(DW), .MAX_HOLD(MH), .RES_LAT(RL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: grantee as an integer (-1 = nobody), pointer, hold count,
  // and a list of issues (cycle number, issuer).
  int m_owner;
  int m_ptr;
  int m_hold;
  int cyc;
  int iss_cyc[$];
  int iss_who[$];
  logic [DW-1:0] d [NREQ];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int rr(input logic [NREQ-1:0] m, input int start);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (start + k) % NREQ;
      if (m[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
    iss_cyc.delete();
    iss_who.delete();
  endtask

  task automatic model_take(input int w);
    m_owner = w;
    m_ptr   = (w + 1) % NREQ;
    m_hold  = 0;
  endtask

  task automatic model_advance(input logic [NREQ-1:0] r);
    int w;
    logic [NREQ-1:0] others;
    if (m_owner >= 0 && r[m_owner]) begin
      iss_cyc.push_back(cyc);
      iss_who.push_back(m_owner);
    end
    if (m_owner < 0) begin
      w = rr(r, m_ptr);
      if (w >= 0) model_take(w);
    end else if (!r[m_owner]) begin
      w = rr(r, m_ptr);
      if (w >= 0) model_take(w);
      else begin
        m_owner = -1;
        m_hold  = 0;
      end
    end else if (m_hold == MH - 1) begin
      others = r;
      others[m_owner] = 1'b0;
      w = rr(others, m_ptr);
      if (w >= 0) model_take(w);
      else m_hold = 0;
    end else begin
      m_hold++;
    end
  endtask

  task automatic check_outputs(input logic [NREQ-1:0] r);
    logic [NREQ-1:0] eg;
    logic [NREQ-1:0] erv;
    logic            ebusy;
    logic [DW-1:0]   ein;
    eg    = '0;
    ein   = '0;
    erv   = '0;
    ebusy = (m_owner >= 0);
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      ein = d[m_owner];
    end
    while (iss_cyc.size() > 0 && iss_cyc[0] < cyc - RL) begin
      void'(iss_cyc.pop_front());
      void'(iss_who.pop_front());
    end
    foreach (iss_cyc[j]) begin
      if (iss_cyc[j] == cyc - RL) erv[iss_who[j]] = 1'b1;
      if (iss_cyc[j] >= cyc - RL) ebusy = 1'b1;
    end
    chk("grant",          64'(bif.grant),          64'(eg));
    chk("onehot0",        64'($onehot0(bif.grant)), 64'(1));
    chk("owner",          64'(bif.owner),          64'((m_owner < 0) ? 0 : m_owner));
    chk("resource_input", 64'(bif.resource_input), 64'(ein));
    chk("resource_valid", 64'(bif.resource_valid), 64'((m_owner >= 0) && r[m_owner]));
    chk("rsp_valid",      64'(bif.rsp_valid),      64'(erv));
    chk("rsp_data",       64'(bif.rsp_data),       64'(bif.resource_output));
    chk("busy",           64'(bif.busy),           64'(ebusy));
  endtask

  // One clock cycle: drive inputs, check at the falling edge, advance the model at the rising edge.
  task automatic step(input logic [NREQ-1:0] r, input logic rn);
    bif.req = r;
    reset   = rn;
    for (int i = 0; i < NREQ; i++) begin
      d[i] = $urandom;
      bif.req_data[i*DW +: DW] = d[i];
    end
    bif.resource_output = $urandom;
    @(negedge clk);
    check_outputs(r);
    if (!rn) model_reset();
    else     model_advance(r);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [NREQ-1:0] r;
    cyc                 = 100;
    reset               = 1'b0;
    bif.req             = '0;
    bif.req_data        = '0;
    bif.resource_output = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state, then idle for 10 cycles.
    for (int i = 0; i < 11; i++) step(4'b0000, 1'b1);

    // Single requester on index 2 with an incrementing data pattern.
    for (int i = 0; i < 5; i++) begin
      bif.req = 4'b0100;
      reset   = 1'b1;
      for (int k = 0; k < NREQ; k++) begin
        d[k] = (k == 2) ? DW'(32'hA0 + i) : DW'($urandom);
        bif.req_data[k*DW +: DW] = d[k];
      end
      bif.resource_output = $urandom;
      @(negedge clk);
      check_outputs(4'b0100);
      model_advance(4'b0100);
      cyc++;
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < RL + 2; i++) step(4'b0000, 1'b1);

    // All requesting: forced handoff every MAX_HOLD cycles, no bubbles.
    for (int i = 0; i < 16; i++) step(4'b1111, 1'b1);
    for (int i = 0; i < RL + 1; i++) step(4'b0000, 1'b1);

    // Early release: owner 0 drops after one cycle while requester 3 waits.
    step(4'b0000, 1'b0);
    step(4'b0001, 1'b1);
    step(4'b1001, 1'b1);
    step(4'b1000, 1'b1);
    step(4'b1000, 1'b1);
    for (int i = 0; i < RL + 1; i++) step(4'b0000, 1'b1);

    // Response tagging across a handoff: requester 1 then requester 2.
    step(4'b0010, 1'b1);
    step(4'b0110, 1'b1);
    step(4'b0100, 1'b1);
    for (int i = 0; i < RL + 2; i++) step(4'b0000, 1'b1);

    // Reset mid-burst with results in flight, then requester 1 wins from ptr 0.
    for (int i = 0; i < 4; i++) step(4'b1111, 1'b1);
    step(4'b1111, 1'b0);
    step(4'b1010, 1'b1);
    step(4'b1010, 1'b1);
    step(4'b1010, 1'b1);

    // Random traffic with sticky requests and occasional resets.
    r = '0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      step(r, ($urandom_range(0, 79) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/shared_resource_arbiter.md
# shared_resource_arbiter

Round-robin arbiter that shares a single downstream resource among NUM_REQ pipeline_top instances. Each pipeline raises `req` from its out_valid path and receives a registered one-hot `grant` that it uses as its arbiter_grant, so pipelines without a grant stall. The winning pipeline's data is muxed onto the resource input. Resource results return after a fixed latency and are tagged back to the issuing requester through an internal shift pipeline.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- DATA_W, 32, resource data width
- MAX_HOLD, 8, max consecutive granted cycles while another requester waits (>=1)
- RES_LAT, 1, fixed resource latency in cycles (>=1)

- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- req  in  NUM_REQ  per-requester request level
- req_data  in  NUM_REQ*DATA_W  requester i data at bits [i*DATA_W +: DATA_W]
- resource_output  in  DATA_W  result from resource, valid RES_LAT cycles after issue
- grant  out  NUM_REQ  registered, one-hot or zero
- owner  out  clog2(NUM_REQ)  index of current grantee (0 when idle)
- resource_input  out  DATA_W  req_data of owner; 0 when idle
- resource_valid  out  1  grant[owner] & req[owner]
- rsp_data  out  DATA_W  resource_output passthrough, broadcast
- rsp_valid  out  NUM_REQ  one-hot tag: issuer of the result on rsp_data
- busy  out  1  any grant or any in-flight response

## Operation
- States: IDLE (grant==0), GRANTED (exactly one grant bit high).
- RR pointer `ptr`: search starts at ptr, wraps modulo NUM_REQ; the first requester with req=1 wins. On every new grant, ptr <= winner+1 (with wrap).
- IDLE: any req -> next cycle grant[winner]=1, hold_cnt=0, GRANTED. No req -> stay.
- GRANTED, evaluated each cycle:
  - req[owner]=0 -> release. If others are requesting, grant passes directly to the RR winner next cycle (no bubble). Otherwise -> IDLE.
  - req[owner]=1, hold_cnt==MAX_HOLD-1, another req pending -> forced handoff to the RR winner among the others next cycle, hold_cnt=0.
  - req[owner]=1, hold_cnt==MAX_HOLD-1, no other req -> keep grant, hold_cnt=0.
  - Otherwise -> keep grant, hold_cnt++. hold_cnt is clog2(MAX_HOLD)+1 bits and never exceeds MAX_HOLD-1.
- The grant never changes to a requester whose req is 0. The grant never has two bits high.
- Issue tag pipeline: RES_LAT stages of {valid, owner}. Stage 0 loads {resource_valid, owner}. rsp_valid = onehot(last stage owner) gated by last stage valid.
- A requester that loses its grant still receives its in-flight responses.

## Timing
- Reset (reset==0 at edge):
  - grant=0, owner=0, ptr=0, hold_cnt=0, tag pipeline cleared.
  - resource_input=0, resource_valid=0, rsp_valid=0, busy=0.
  - Reset mid-operation discards in-flight tags; no rsp_valid after reset.
- Request-to-grant latency: 1 cycle (req high at edge N, grant high after edge N+1).
- resource_input and resource_valid are combinational from the registered grant/owner and live req/req_data.
- Issue at cycle N -> rsp_valid for that requester at cycle N+RES_LAT, aligned with resource_output.
- Back-to-back issue: 1 result per cycle, no stalls inside the arbiter.
- Simultaneous release and new req from the same requester: that requester is excluded for one cycle, because ptr has moved past it.

## Test plan
- Single requester: NUM_REQ=4, req[2]=1 for 5 cycles, data 0xA0..0xA4 -> grant=0100 from cycle 1 to 5, resource_input follows the data, rsp_valid=0100 one cycle later with rsp_data = resource_output, hold never forces a handoff.
- All requesting, MAX_HOLD=2: req=1111 continuously -> grant sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001..., no bubbles, never multi-hot.
- Early release: owner 0 drops req after 1 cycle while req[3]=1 -> grant moves 0001->1000 on the next cycle, hold_cnt restarts at 0.
- Response tagging across handoff, RES_LAT=3: issue from requester 1 then requester 2 on consecutive cycles -> rsp_valid 0010 then 0100 exactly 3 cycles after each issue.
- Reset mid-burst: assert reset=0 while granted with 2 results in flight -> next cycle grant=0, rsp_valid=0, busy=0. After release, req[1]=1 is granted first because ptr=0.
- Idle: req=0 for 10 cycles -> grant=0, resource_valid=0, resource_input=0, busy=0.
